// File: rtl/down_counter_if.sv
// -----------------------------------------------------------------------------
// down_counter_if
// Groups the control inputs and status outputs of down_counter.
//   load/load_val : capture a new start value (and reload value)
//   start         : begin or restart a countdown
//   en            : count enable
//   auto_reload   : periodic-mode select (honoured only with DOWN_CNT_RELOAD_EN)
//   q/tc/busy/done: registered count and status returned by the counter
// Modports: master drives control and reads status; slave is the counter side.
// -----------------------------------------------------------------------------
interface down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, en, auto_reload,
        input  q, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, en, auto_reload,
        output q, tc, busy, done
    );
endinterface

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable, enable-gated down counter with a one-cycle terminal-count pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : down_counter_if.slave (load, load_val, start, en, auto_reload in;
//          q, tc, busy, done out, all registered)
// Optional feature: define DOWN_CNT_RELOAD_EN to honour auto_reload (periodic
// mode). Without it the auto_reload input is ignored and every count is
// one-shot.
// Input priority in every state: load > start > en.
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    down_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_next_s;
    logic             tc_r;
    logic             tc_next_s;
    logic             busy_r;
    logic             done_r;
    logic             reload_mode_s;

`ifdef DOWN_CNT_RELOAD_EN
    assign reload_mode_s = bus.auto_reload;
`else
    // Periodic mode is compiled out; the port is kept for a stable interface.
    logic unused_auto_reload_s;
    assign unused_auto_reload_s = bus.auto_reload;
    assign reload_mode_s        = 1'b0;
`endif

    // Next-state, next-count and terminal-count decode.
    always_comb begin
        state_next_s  = state_r;
        q_next_s      = q_r;
        reload_next_s = reload_r;
        tc_next_s     = 1'b0;

        if (bus.load) begin
            // Load aborts whatever is in progress and never raises tc.
            q_next_s      = bus.load_val;
            reload_next_s = bus.load_val;
            state_next_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (q_r != ZERO) begin
                            state_next_s = ST_RUN;
                        end else begin
                            // Zero-length countdown terminates immediately.
                            state_next_s = ST_DONE;
                            tc_next_s    = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (bus.start) begin
                        // Restart from the stored start value.
                        if (reload_r != ZERO) begin
                            q_next_s     = reload_r;
                            state_next_s = ST_RUN;
                        end else begin
                            q_next_s     = ZERO;
                            state_next_s = ST_DONE;
                            tc_next_s    = 1'b1;
                        end
                    end else if (bus.en) begin
                        if (q_r > ONE) begin
                            q_next_s = q_r - ONE;
                        end else if (q_r == ONE) begin
                            tc_next_s = 1'b1;
                            if (reload_mode_s && (reload_r != ZERO)) begin
                                q_next_s     = reload_r;
                                state_next_s = ST_RUN;
                            end else begin
                                q_next_s     = ZERO;
                                state_next_s = ST_DONE;
                            end
                        end else begin
                            // q==0 cannot occur in RUN; retire safely, no tc.
                            q_next_s     = ZERO;
                            state_next_s = ST_DONE;
                        end
                    end else begin
                        q_next_s = q_r;
                    end
                end

                ST_DONE: begin
                    if (bus.start) begin
                        if (reload_r != ZERO) begin
                            q_next_s     = reload_r;
                            state_next_s = ST_RUN;
                        end else begin
                            q_next_s     = ZERO;
                            state_next_s = ST_DONE;
                            tc_next_s    = 1'b1;
                        end
                    end else begin
                        q_next_s = ZERO;
                    end
                end

                default: begin
                    // Illegal encoding: return to a known quiet state.
                    q_next_s     = ZERO;
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            q_r      <= ZERO;
            reload_r <= ZERO;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            q_r      <= q_next_s;
            reload_r <= reload_next_s;
            tc_r     <= tc_next_s;
            // Status flags are registered from the next state so they track it.
            busy_r   <= (state_next_s == ST_RUN);
            done_r   <= (state_next_s == ST_DONE);
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
